// File: rtl/desc_window_tracker.sv
// Sliding 3-sample window over a framed stream that reports per-sample descending-order
// flags and strictly-descending run statistics through a single registered result stage.
module desc_window_tracker #(
    parameter int unsigned k  = 8,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [k-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          strict_desc,
    output logic          nonincr,
    output logic          window_full,
    output logic [CW-1:0] run_len,
    output logic [CW-1:0] max_run,
    output logic          frame_done
);

    localparam logic [CW-1:0] RUN_MAX = '1;
    localparam logic [1:0]    FILL_MAX = 2'd3;

    logic [k-1:0]  w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
    logic [1:0]    fill_q, fill_d;
    logic          frame_start_q, frame_start_d;
    logic          out_valid_q, out_valid_d;
    logic          strict_q, strict_d;
    logic          nonincr_q, nonincr_d;
    logic          full_q, full_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] max_q, max_d;
    logic          done_q, done_d;
    logic          accept;

    // Single result register: accept whenever it is empty or being drained this cycle.
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state: shift window, update fill/run stats and evaluate flags on the post-shift window.
    always_comb begin
        w0_d          = w0_q;
        w1_d          = w1_q;
        w2_d          = w2_q;
        fill_d        = fill_q;
        frame_start_d = frame_start_q;
        out_valid_d   = out_valid_q && !out_ready;
        strict_d      = strict_q;
        nonincr_d     = nonincr_q;
        full_d        = full_q;
        run_d         = run_q;
        max_d         = max_q;
        done_d        = done_q;

        if (accept) begin
            w0_d          = in_data;
            w1_d          = w0_q;
            w2_d          = w1_q;
            frame_start_d = in_last;
            out_valid_d   = 1'b1;
            done_d        = in_last;

            if (frame_start_q) begin
                fill_d = 2'd1;
                run_d  = CW'(1);
                max_d  = CW'(1);
            end else begin
                fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 2'd1;
                if (in_data < w0_q) begin
                    run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + CW'(1);
                end else begin
                    run_d = CW'(1);
                end
                max_d = (run_d > max_q) ? run_d : max_q;
            end

            // Fill gating keeps samples from a previous frame out of the flags.
            full_d    = (fill_d == FILL_MAX);
            strict_d  = full_d && (w2_d > w1_d) && (w1_d > w0_d);
            nonincr_d = full_d && (w2_d >= w1_d) && (w1_d >= w0_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q          <= '0;
            w1_q          <= '0;
            w2_q          <= '0;
            fill_q        <= 2'd0;
            frame_start_q <= 1'b1;
            out_valid_q   <= 1'b0;
            strict_q      <= 1'b0;
            nonincr_q     <= 1'b0;
            full_q        <= 1'b0;
            run_q         <= '0;
            max_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            w0_q          <= w0_d;
            w1_q          <= w1_d;
            w2_q          <= w2_d;
            fill_q        <= fill_d;
            frame_start_q <= frame_start_d;
            out_valid_q   <= out_valid_d;
            strict_q      <= strict_d;
            nonincr_q     <= nonincr_d;
            full_q        <= full_d;
            run_q         <= run_d;
            max_q         <= max_d;
            done_q        <= done_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign strict_desc = strict_q;
    assign nonincr     = nonincr_q;
    assign window_full = full_q;
    assign run_len     = run_q;
    assign max_run     = max_q;
    assign frame_done  = done_q;

endmodule
